// File: rtl/ahsqr_pkg.sv
// Shared parameters, elaboration helpers and reference model for the AHSQR pipelined root.
package ahsqr_pkg;

   typedef struct packed {
      logic [31:0] root;
      logic [31:0] rem;
   } ahsqr_res_t;

   function automatic int unsigned ahsqr_out_w(input int unsigned in_w);
      return in_w / 2;
   endfunction

   function automatic int unsigned ahsqr_stages(input int unsigned in_w, input int unsigned k);
      return in_w / 2 - k / 2;
   endfunction

   // Midpoint of the dropped root bits; recentres the truncation error.
   function automatic int unsigned ahsqr_comp(input int unsigned k);
      return (k > 0) ? (32'd1 << (k / 2 - 1)) : 32'd0;
   endfunction

   function automatic bit ahsqr_params_ok(input int unsigned in_w, input int unsigned k);
      return (in_w % 2 == 0) && (in_w >= 4) && (k % 2 == 0) && (k + 2 <= in_w);
   endfunction

   // Behavioural reference: bitwise search for floor(sqrt(R >> K)).
   function automatic ahsqr_res_t ahsqr_model(input logic [63:0] r, input int unsigned k);
      logic [63:0] t;
      logic [63:0] q;
      logic [63:0] c;
      ahsqr_res_t  res;
      t = r >> k;
      q = '0;
      for (int b = 31; b >= 0; b--) begin
         c = q | (64'd1 << b);
         if (c * c <= t) q = c;
      end
      res.rem  = 32'(t - q * q);
      res.root = 32'((q << (k / 2)) | 64'(ahsqr_comp(k)));
      return res;
   endfunction

endpackage

// File: rtl/ahsqr_stage.sv
// One non-restoring square-root digit step: consumes two radicand bits, yields one root bit.
module ahsqr_stage #(
   parameter int unsigned S = 6
) (
   input  logic [S+1:0] rem,
   input  logic [S-1:0] root,
   input  logic [1:0]   bits,
   output logic [S+1:0] rem_nxt,
   output logic [S-1:0] root_nxt
);
   localparam int unsigned RW = S + 2;

   logic [RW-1:0] shifted;

   // Width RW keeps one spare sign bit; wraparound arithmetic is exact within that range.
   always_comb begin
      shifted = {rem[RW-3:0], bits};
      if (rem[RW-1]) begin
         rem_nxt = shifted + {root, 2'b11};
      end else begin
         rem_nxt = shifted - {root, 2'b01};
      end
      root_nxt = S'({root, ~rem_nxt[RW-1]});
   end

endmodule

// File: rtl/ahsqr_pipe.sv
// Pipelined approximate square root with valid/ready back-pressure and a sideband tag.
// Define AHSQR_REM_EN to compile in the corrected remainder output out_rem.
module ahsqr_pipe
   import ahsqr_pkg::*;
#(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned K     = 4,
   parameter int unsigned TAG_W = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [IN_W-1:0]        in_r,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [IN_W/2-1:0]      out_root,
   output logic [TAG_W-1:0]       out_tag
`ifdef AHSQR_REM_EN
   ,
   output logic [IN_W/2-K/2:0]    out_rem
`endif
);
   localparam int unsigned OUT_W = ahsqr_out_w(IN_W);
   localparam int unsigned S     = ahsqr_stages(IN_W, K);
   localparam int unsigned RW    = S + 2;
   localparam int unsigned TW    = 2 * S;
   localparam logic [OUT_W-1:0] COMP = OUT_W'(ahsqr_comp(K));

   if (!ahsqr_params_ok(IN_W, K) || TAG_W < 1) begin : g_param_err
      $error("ahsqr_pipe: illegal IN_W/K/TAG_W combination");
   end

   logic                adv;
   logic [S:0]          vld_q;
   logic [TAG_W-1:0]    tag_q  [S+1];
   logic [TW-1:0]       opnd_q [S];
   logic [RW-1:0]       rem_q  [S];
   logic [S-1:0]        root_q [S];
   logic [OUT_W-1:0]    out_root_q;
   logic [RW-1:0]       st_rem [S];
   logic [RW-1:0]       rem_d  [S];
   logic [S-1:0]        root_d [S];

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   for (genvar i = 0; i < S; i++) begin : g_stage
      logic [RW-1:0] rem_in;
      logic [S-1:0]  root_in;
      if (i == 0) begin : g_first
         assign rem_in  = '0;
         assign root_in = '0;
      end else begin : g_next
         assign rem_in  = rem_q[i-1];
         assign root_in = root_q[i-1];
      end
      ahsqr_stage #(
         .S (S)
      ) u_stage (
         .rem      (rem_in),
         .root     (root_in),
         .bits     (opnd_q[i][TW-1-2*i -: 2]),
         .rem_nxt  (st_rem[i]),
         .root_nxt (root_d[i])
      );
   end

   // A negative final remainder means the last trial overshot by 2q+1.
   always_comb begin
      for (int unsigned j = 0; j < S; j++) rem_d[j] = st_rem[j];
`ifdef AHSQR_REM_EN
      if (st_rem[S-1][RW-1]) begin
         rem_d[S-1] = st_rem[S-1] + RW'({root_d[S-1], 1'b1});
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q      <= '0;
         out_root_q <= '0;
         for (int unsigned j = 0; j <= S; j++) tag_q[j] <= '0;
         for (int unsigned j = 0; j < S; j++) begin
            opnd_q[j] <= '0;
            rem_q[j]  <= '0;
            root_q[j] <= '0;
         end
      end else if (adv) begin
         vld_q     <= {vld_q[S-1:0], in_valid};
         tag_q[0]  <= in_tag;
         opnd_q[0] <= in_r[IN_W-1:K];
         for (int unsigned j = 1; j <= S; j++) tag_q[j] <= tag_q[j-1];
         for (int unsigned j = 1; j < S; j++) opnd_q[j] <= opnd_q[j-1];
         for (int unsigned j = 0; j < S; j++) begin
            rem_q[j]  <= rem_d[j];
            root_q[j] <= root_d[j];
         end
         out_root_q <= (OUT_W'(root_d[S-1]) << (K / 2)) | COMP;
      end
   end

   assign out_valid = vld_q[S];
   assign out_tag   = tag_q[S];
   assign out_root  = out_root_q;
`ifdef AHSQR_REM_EN
   assign out_rem   = rem_q[S-1][S:0];
`endif

endmodule

// File: tb/tb_ahsqr_pipe.sv
// Directed and randomised bench for ahsqr_pipe: three configurations (16/4, 16/0, 24/2).
module tb_ahsqr_pipe;
   import ahsqr_pkg::*;

   typedef struct {
      logic [63:0] root;
      logic [63:0] rem;
      logic [63:0] tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  in_valid;
   logic [2:0]  out_ready;
   wire  [2:0]  in_ready_w;
   wire  [2:0]  out_valid_w;
   logic [23:0] in_r   [3];
   logic [3:0]  in_tag [3];
   wire  [7:0]  root0, root1;
   wire  [11:0] root2;
   wire  [3:0]  tag0, tag1, tag2;
`ifdef AHSQR_REM_EN
   wire  [6:0]  rem0;
   wire  [8:0]  rem1;
   wire  [11:0] rem2;
`endif

   int n_checks = 0;
   int n_errors = 0;
   exp_t sb[$];

   logic [15:0] b2b_r    [3] = '{16'hD399, 16'hFFFF, 16'h0000};
   int          b2b_root [3] = '{234, 254, 2};
   int          b2b_rem  [3] = '{21, 126, 0};
   int unsigned cfg_inw  [3] = '{16, 16, 24};
   int unsigned cfg_k    [3] = '{4, 0, 2};

   always #5 clk = ~clk;

   ahsqr_pipe #(.IN_W(16), .K(4), .TAG_W(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
      .in_r(in_r[0][15:0]), .in_tag(in_tag[0]), .out_valid(out_valid_w[0]),
      .out_ready(out_ready[0]), .out_root(root0), .out_tag(tag0)
`ifdef AHSQR_REM_EN
      , .out_rem(rem0)
`endif
   );

   ahsqr_pipe #(.IN_W(16), .K(0), .TAG_W(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
      .in_r(in_r[1][15:0]), .in_tag(in_tag[1]), .out_valid(out_valid_w[1]),
      .out_ready(out_ready[1]), .out_root(root1), .out_tag(tag1)
`ifdef AHSQR_REM_EN
      , .out_rem(rem1)
`endif
   );

   ahsqr_pipe #(.IN_W(24), .K(2), .TAG_W(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
      .in_r(in_r[2]), .in_tag(in_tag[2]), .out_valid(out_valid_w[2]),
      .out_ready(out_ready[2]), .out_root(root2), .out_tag(tag2)
`ifdef AHSQR_REM_EN
      , .out_rem(rem2)
`endif
   );

   task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, obs, exp);
      end
   endtask

   task automatic peek(input int idx, output logic [63:0] root, output logic [63:0] tag,
                       output logic [63:0] rem);
      rem = '0;
      case (idx)
         0: begin
            root = 64'(root0); tag = 64'(tag0);
`ifdef AHSQR_REM_EN
            rem = 64'(rem0);
`endif
         end
         1: begin
            root = 64'(root1); tag = 64'(tag1);
`ifdef AHSQR_REM_EN
            rem = 64'(rem1);
`endif
         end
         default: begin
            root = 64'(root2); tag = 64'(tag2);
`ifdef AHSQR_REM_EN
            rem = 64'(rem2);
`endif
         end
      endcase
   endtask

   task automatic wait_valid(input int idx, input int bound, output int cyc);
      cyc = 0;
      while (out_valid_w[idx] !== 1'b1 && cyc < bound) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic single(input int idx, input logic [23:0] r, input logic [3:0] tg,
                         input int exp_lat, input int exp_root, input int exp_rem,
                         input string nm);
      int          cyc;
      logic [63:0] ro, ta, re;
      @(negedge clk);
      in_valid[idx] = 1'b1;
      in_r[idx]     = r;
      in_tag[idx]   = tg;
      @(posedge clk);
      #1;
      in_valid[idx] = 1'b0;
      wait_valid(idx, 20, cyc);
      check_eq({nm, "_lat"}, 64'(cyc), 64'(exp_lat));
      peek(idx, ro, ta, re);
      check_eq({nm, "_root"}, ro, 64'(exp_root));
      check_eq({nm, "_tag"}, ta, 64'(tg));
`ifdef AHSQR_REM_EN
      check_eq({nm, "_rem"}, re, 64'(exp_rem));
`endif
   endtask

   task automatic run_random(input int idx, input int n);
      int          sent = 0;
      int          got = 0;
      int          cyc = 0;
      logic [63:0] mask;
      logic [63:0] ro, ta, re;
      ahsqr_res_t  m;
      exp_t        e;
      mask = (64'd1 << cfg_inw[idx]) - 64'd1;
      sb.delete();
      while (got < n && cyc < n * 6 + 200) begin
         @(negedge clk);
         if (sent < n) begin
            in_valid[idx] = ($urandom_range(0, 99) < 70);
            in_r[idx]     = 24'(64'($urandom) & mask);
            in_tag[idx]   = 4'($urandom);
         end else begin
            in_valid[idx] = 1'b0;
         end
         out_ready[idx] = ($urandom_range(0, 99) < 70);
         #1;
         if (in_valid[idx] && in_ready_w[idx]) begin
            m = ahsqr_model(64'(in_r[idx]) & mask, cfg_k[idx]);
            e.root = 64'(m.root);
            e.rem  = 64'(m.rem);
            e.tag  = 64'(in_tag[idx]);
            sb.push_back(e);
            sent++;
         end
         if (out_valid_w[idx] && out_ready[idx]) begin
            check_eq("rnd_pending", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               peek(idx, ro, ta, re);
               check_eq("rnd_root", ro, e.root);
               check_eq("rnd_tag", ta, e.tag);
`ifdef AHSQR_REM_EN
               check_eq("rnd_rem", re, e.rem);
`endif
            end
            got++;
         end
         cyc++;
      end
      @(negedge clk);
      in_valid[idx]  = 1'b0;
      out_ready[idx] = 1'b1;
      check_eq("rnd_count", 64'(got), 64'(n));
      check_eq("rnd_left", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int          cyc;
      int          k;
      int          seen;
      logic [63:0] ro, ta, re;
      logic [15:0] v;
      ahsqr_res_t  m;
      exp_t        e;

      rst_n     = 1'b0;
      in_valid  = '0;
      out_ready = '1;
      for (int i = 0; i < 3; i++) begin
         in_r[i]   = '0;
         in_tag[i] = '0;
      end

      // Reset values.
      #12;
      peek(0, ro, ta, re);
      check_eq("rst_out_valid", 64'(out_valid_w[0]), 64'd0);
      check_eq("rst_in_ready", 64'(in_ready_w[0]), 64'd1);
      check_eq("rst_out_root", ro, 64'd0);
      check_eq("rst_out_tag", ta, 64'd0);
`ifdef AHSQR_REM_EN
      check_eq("rst_out_rem", re, 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Single operand latency and arithmetic.
      single(0, 24'hFF80, 4'd5, 6, 254, 119, "k4_ff80");
      single(1, 24'hFFFF, 4'd9, 8, 255, 510, "k0_ffff");

      // Back-to-back operands at full rate.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid[0] = 1'b1;
         in_r[0]     = 24'(b2b_r[i]);
         in_tag[0]   = 4'(i + 1);
      end
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      wait_valid(0, 20, cyc);
      check_eq("b2b_lat", 64'(cyc), 64'd4);
      for (int i = 0; i < 3; i++) begin
         peek(0, ro, ta, re);
         check_eq("b2b_valid", 64'(out_valid_w[0]), 64'd1);
         check_eq("b2b_root", ro, 64'(b2b_root[i]));
         check_eq("b2b_tag", ta, 64'(i + 1));
`ifdef AHSQR_REM_EN
         check_eq("b2b_rem", re, 64'(b2b_rem[i]));
`endif
         @(posedge clk);
         #1;
      end
      check_eq("b2b_end", 64'(out_valid_w[0]), 64'd0);

      // Stall: fill the pipe with the consumer blocked, then drain.
      @(negedge clk);
      out_ready[0] = 1'b0;
      sb.delete();
      k = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         v           = 16'(32'h1357 * (k + 3));
         in_valid[0] = 1'b1;
         in_r[0]     = 24'(v);
         in_tag[0]   = 4'(k);
         #1;
         if (in_ready_w[0]) begin
            m      = ahsqr_model(64'(v), 4);
            e.root = 64'(m.root);
            e.rem  = 64'(m.rem);
            e.tag  = 64'(k);
            sb.push_back(e);
            k++;
         end
      end
      check_eq("stall_accepts", 64'(k), 64'd7);
      in_tag[0] = 4'd15;
      for (int h = 0; h < 5; h++) begin
         @(posedge clk);
         #1;
         peek(0, ro, ta, re);
         check_eq("stall_in_ready", 64'(in_ready_w[0]), 64'd0);
         check_eq("stall_valid", 64'(out_valid_w[0]), 64'd1);
         check_eq("stall_root", ro, sb[0].root);
         check_eq("stall_tag", ta, sb[0].tag);
      end
      @(negedge clk);
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         peek(0, ro, ta, re);
         check_eq("drain_valid", 64'(out_valid_w[0]), 64'd1);
         check_eq("drain_root", ro, e.root);
         check_eq("drain_tag", ta, e.tag);
`ifdef AHSQR_REM_EN
         check_eq("drain_rem", re, e.rem);
`endif
         @(posedge clk);
         #1;
      end
      check_eq("drain_end", 64'(out_valid_w[0]), 64'd0);

      // Reset with operands in flight.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid[0] = 1'b1;
         in_r[0]     = 24'(16'hA000 + i);
         in_tag[0]   = 4'(i + 4);
      end
      @(negedge clk);
      in_valid[0] = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      peek(0, ro, ta, re);
      check_eq("mrst_out_valid", 64'(out_valid_w[0]), 64'd0);
      check_eq("mrst_in_ready", 64'(in_ready_w[0]), 64'd1);
      check_eq("mrst_out_root", ro, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk);
         #1;
         if (out_valid_w[0]) seen++;
      end
      check_eq("mrst_no_output", 64'(seen), 64'd0);

      // Random traffic with back-pressure on each configuration.
      run_random(0, 4000);
      run_random(1, 3000);
      run_random(2, 3000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ahsqr_pipe.md
# ahsqr_pipe

Pipelined, parametrised approximate integer square root for the Sobel edge-magnitude path. It is the clocked successor to the combinational k=4 AHSQR root. The input width and the approximation depth K are parameters. Data moves through a valid/ready stream with full back-pressure and carries a sideband tag. The block accepts one operand per cycle and returns the approximate root of a gradient sum-of-squares after a fixed latency.

## Interface
- IN_W, 16, operand width; must be even and ≥ 4.
- K, 4, number of operand LSBs dropped by the approximation; even, 0 ≤ K ≤ IN_W-2; K=0 gives the exact root.
- TAG_W, 4, sideband tag width; ≥ 1.
- Derived: OUT_W = IN_W/2. S = OUT_W - K/2 is the stage count and the latency.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand present.
- in_ready  out  1  block can accept the operand this cycle.
- in_r  in  IN_W  unsigned operand R.
- in_tag  in  TAG_W  sideband, returned unchanged with the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_root  out  OUT_W  approximate root.
- out_tag  out  TAG_W  tag of this result.
- out_rem  out  S+1  remainder; this port exists only under AHSQR_REM_EN.

## Operation
- Arithmetic, all unsigned:
  - T = in_r >> K.
  - q = floor(sqrt(T)), an S-bit value.
  - out_root = (q << K/2) | C, where C = 1 << (K/2-1) when K>0 and C = 0 when K=0.
  - The midpoint compensation C halves the bias of truncation.
  - The result cannot overflow OUT_W.
- Algorithm: non-restoring digit recurrence, one root bit per stage, MSB first.
  - Stage i (0..S-1) consumes 2 bits of T.
  - It updates the partial remainder (S+1 bits, signed during the recurrence) and the partial root.
  - The final remainder is corrected to be non-negative, so rem = T - q².
- Pipeline control:
  - Each stage has a valid bit plus data registers.
  - Global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv.
  - A transfer occurs when in_valid && in_ready. An out transfer occurs when out_valid && out_ready.
  - When adv = 1, every stage register loads from its predecessor. Stage 0 loads in_valid with the operand.
  - When adv = 0, all stages hold.
  - Bubbles are not collapsed.
- Reset, asynchronous while rst_n = 0:
  - All valid bits clear and all data registers clear.
  - Reset values: out_valid = 0, out_root = 0, out_tag = 0, out_rem = 0, in_ready = 1.
- Reset during operation discards every in-flight operand. No partial result is emitted.
- in_r and in_tag are don't-care when in_valid = 0. X on data must not propagate into any valid bit.

## Timing
- Latency: an operand accepted at edge n presents out_valid = 1 with its result after edge n+S, given no stalls. Each stall cycle adds 1.
- Throughput: 1 result/cycle when out_ready is held at 1.
- Outputs are registered; there is no combinational path from in_* to out_*.
- in_ready depends combinationally on out_ready and the registered out_valid only.
- Output stability: while out_valid && !out_ready, out_root, out_tag and out_rem stay stable and no transfer into the block occurs.
- Simultaneous events:
  - An output transfer and an input acceptance in the same cycle are legal and required for full rate.
  - rst_n deassertion must be synchronised externally. The first accept is permitted on the first edge after release.

## Configuration
- AHSQR_REM_EN defined:
  - The out_rem port and the remainder pipeline are compiled in.
  - out_rem = T - q², range 0..2q.
- AHSQR_REM_EN undefined:
  - The out_rem port is absent.
  - Remainder correction after the last stage is removed.
  - The partial remainder is still carried, because the recurrence needs it.
  - out_root and out_tag behaviour and latency are identical in both builds.

## Structure
- Package ahsqr_pkg holds:
  - functions computing OUT_W, S and C from IN_W/K;
  - elaboration checks on legal IN_W/K;
  - a reference function ahsqr_model(R, K) for the bench.
- Sub-module ahsqr_stage: one combinational recurrence step (partial remainder, partial root, next 2 operand bits in; updated pair out).
  - ahsqr_pipe instantiates S of them via generate and owns all registers and handshake logic.

## Test plan
- IN_W=16, K=4, R=16'hFF80 -> out_root=254, out_rem=119, S=6 cycles after accept.
- IN_W=16, K=4, back-to-back R=16'hD399, 16'hFFFF, 16'h0000 with tags 1,2,3 -> roots 234, 254, 2 and tags 1,2,3, on consecutive cycles.
- IN_W=16, K=0, R=16'hFFFF -> out_root=255, out_rem=510, latency 8.
- Stall: hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0, outputs stable, no loss or duplication. Release -> full drain in order.
- Reset: assert rst_n=0 mid-stream with 3 operands in flight -> out_valid=0 immediately, in_ready=1, nothing emitted after release.
- Random: 10k operands with random in_valid/out_ready, IN_W ∈ {16,24}, K ∈ {0,2,4} -> every result matches ahsqr_model, in order.
